// File: rtl/alu_vector_gen.sv
// rtl/alu_vector_gen.sv - ALU stimulus vector generator with record handshake
//
// Purpose:
//   Drives LFSR-derived operand/opcode vectors onto an external combinational
//   ALU. It captures each result one cycle later and presents the vector and
//   the result as a record on a valid/ready handshake.
//   Optional macro VECGEN_DIRECTED_EN makes vectors 0..7 directed
//   (a = all ones, b = 1, op = index).
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   run request, sampled only while idle
//   busy        out  high whenever the generator is not idle
//   done        out  one-cycle pulse at the end of a run
//   alu_a/b     out  registered operands to the ALU (N bits)
//   alu_op      out  registered opcode to the ALU
//   alu_y       in   ALU result, valid one cycle after the operands change
//   rec_valid   out  record valid
//   rec_ready   in   record accepted by the consumer
//   rec_a/b     out  record operands (N bits)
//   rec_op      out  record opcode
//   rec_y       out  record ALU result (N bits)
//   rec_idx     out  zero-based record index

module alu_vector_gen #(
  parameter int          N       = 16,
  parameter int          NUM_VEC = 64,
  parameter logic [31:0] SEED    = 32'hACE1_2345
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_y,
  output logic         rec_valid,
  input  logic         rec_ready,
  output logic [N-1:0] rec_a,
  output logic [N-1:0] rec_b,
  output logic [2:0]   rec_op,
  output logic [N-1:0] rec_y,
  output logic [15:0]  rec_idx
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] idx;
  logic [31:0] lfsr;

  logic        start_run;
  logic        accept;
  logic        load_vec;

  logic [15:0]  vec_idx;
  logic [31:0]  vec_base;
  logic [31:0]  vec_lfsr;
  logic         vec_directed;
  logic [N-1:0] vec_a;
  logic [N-1:0] vec_b;
  logic [2:0]   vec_op;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  assign start_run = (state == IDLE) && start;
  assign accept    = (state == EMIT) && rec_valid && rec_ready;
  assign load_vec  = start_run || (accept && (idx != LAST_IDX));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next vector. A run start restarts the stream from the seed, so identical
  // runs replay identical vectors; otherwise the stream continues from lfsr.
  always_comb begin
    vec_idx  = (state == IDLE) ? 16'd0 : (idx + 16'd1);
    vec_base = (state == IDLE) ? SEED_EFF : lfsr;
`ifdef VECGEN_DIRECTED_EN
    vec_directed = (vec_idx < 16'd8);
`else
    vec_directed = 1'b0;
`endif
    // Directed vectors leave the LFSR untouched, so vector 8 gets the first
    // random value.
    vec_lfsr = vec_directed ? vec_base : lfsr_step(vec_base);
    vec_a    = vec_directed ? {N{1'b1}} : vec_lfsr[N-1:0];
    vec_b    = vec_directed ? N'(1) : vec_lfsr[31:32-N];
    vec_op   = vec_idx[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = EMIT;
      EMIT:    if (rec_valid && rec_ready) state_nxt = (idx == LAST_IDX) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 16'd0;
      lfsr      <= SEED_EFF;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'd0;
      rec_valid <= 1'b0;
      rec_a     <= '0;
      rec_b     <= '0;
      rec_op    <= 3'd0;
      rec_y     <= '0;
      rec_idx   <= 16'd0;
    end else begin
      if (load_vec) begin
        idx    <= vec_idx;
        lfsr   <= vec_lfsr;
        alu_a  <= vec_a;
        alu_b  <= vec_b;
        alu_op <= vec_op;
      end
      // The ALU result has had one full cycle to settle by the end of DRIVE.
      if (state == DRIVE) begin
        rec_a     <= alu_a;
        rec_b     <= alu_b;
        rec_op    <= alu_op;
        rec_y     <= alu_y;
        rec_idx   <= idx;
        rec_valid <= 1'b1;
      end
      if (accept) begin
        rec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_vector_gen.sv
// tb/tb_alu_vector_gen.sv - self-checking bench for alu_vector_gen

module tb_alu_vector_gen;

  localparam int N  = 16;
  localparam int NV = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, rec_ready;
  logic         busy, done, rec_valid;
  logic [N-1:0] alu_a, alu_b, alu_y, rec_a, rec_b, rec_y;
  logic [2:0]   alu_op, rec_op;
  logic [15:0]  rec_idx;

  logic         start1, ready1;
  logic         busy1, done1, valid1;
  logic [N-1:0] a1, b1, y1, ra1, rb1, ry1;
  logic [2:0]   op1, rop1;
  logic [15:0]  ridx1;

  function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return N'(a < b);
    endcase
  endfunction

  assign alu_y = alu_fn(alu_a, alu_b, alu_op);
  assign y1    = alu_fn(a1, b1, op1);

  alu_vector_gen #(.N(N), .NUM_VEC(NV), .SEED(32'hACE1_2345)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_a(rec_a), .rec_b(rec_b),
    .rec_op(rec_op), .rec_y(rec_y), .rec_idx(rec_idx)
  );

  alu_vector_gen #(.N(N), .NUM_VEC(1), .SEED(32'hACE1_2345)) u_one (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_y(y1),
    .rec_valid(valid1), .rec_ready(ready1), .rec_a(ra1), .rec_b(rb1),
    .rec_op(rop1), .rec_y(ry1), .rec_idx(ridx1)
  );

  typedef struct {
    logic [15:0]  idx;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
  } rec_t;

  typedef struct {
    logic [15:0]  idx;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } tv_t;

  rec_t exp_arr[NV];
  tv_t  tbl[4];

  int checks = 0;
  int failures = 0;
  int nrec, ndone, done_due;
  bit hold;
  logic [127:0] held_rec, held_alu;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference stream: walk the polynomial with plain integer arithmetic.
  task automatic build_model();
    int unsigned s;
    s = 32'hACE1_2345;
    for (int i = 0; i < NV; i++) begin
      bit directed;
      directed = 1'b0;
`ifdef VECGEN_DIRECTED_EN
      directed = (i < 8);
`endif
      if (directed) begin
        exp_arr[i].a = '1;
        exp_arr[i].b = N'(1);
      end else begin
        s = (s >> 1) ^ (((s & 32'd1) != 0) ? 32'h8020_0003 : 32'd0);
        exp_arr[i].a = N'(s);
        exp_arr[i].b = N'(s >> (32 - N));
      end
      exp_arr[i].idx = 16'(i);
      exp_arr[i].op  = 3'(i % 8);
      exp_arr[i].y   = alu_fn(exp_arr[i].a, exp_arr[i].b, exp_arr[i].op);
    end
  endtask

  task automatic mon();
    logic [127:0] cur_rec, cur_alu;
    cur_rec = 128'({rec_valid, rec_a, rec_b, rec_op, rec_y, rec_idx});
    cur_alu = 128'({alu_a, alu_b, alu_op});
    if (hold) begin
      chk("hold_rec_stable", cur_rec, held_rec);
      chk("hold_alu_stable", cur_alu, held_alu);
    end
    hold     = rec_valid && !rec_ready && !rst;
    held_rec = cur_rec;
    held_alu = cur_alu;
    if (done_due == 1) begin
      chk("done_after_last", 128'({done, busy}), 128'(2'b11));
      done_due = 2;
    end else if (done_due == 2) begin
      chk("idle_after_done", 128'({done, busy}), 128'(2'b00));
      done_due = 0;
    end
    if (done) ndone++;
    if (rec_valid && rec_ready && !rst) begin
      if (nrec < NV) begin
        chk("record_fields", 128'({rec_idx, rec_op, rec_a, rec_b, rec_y}),
            128'({exp_arr[nrec].idx, exp_arr[nrec].op, exp_arr[nrec].a,
                  exp_arr[nrec].b, exp_arr[nrec].y}));
        if (rec_idx == 16'(NV - 1)) done_due = 1;
      end else begin
        chk("record_count_bound", 128'(nrec), 128'(NV - 1));
      end
      nrec++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int budget;
    logic [N-1:0] bp_a;

`ifdef VECGEN_DIRECTED_EN
    tbl[0] = '{16'd0, 16'hFFFF, 16'h0001};
    tbl[1] = '{16'd1, 16'hFFFF, 16'h0001};
    tbl[2] = '{16'd2, 16'hFFFF, 16'h0001};
    tbl[3] = '{16'd3, 16'hFFFF, 16'h0001};
`else
    tbl[0] = '{16'd0, 16'h91A1, 16'hD650};
    tbl[1] = '{16'd1, 16'h48D3, 16'hEB08};
    tbl[2] = '{16'd2, 16'h246A, 16'hF5A4};
    tbl[3] = '{16'd3, 16'h1235, 16'h7AD2};
`endif
    build_model();
    rst = 1'b1; start = 1'b0; rec_ready = 1'b0; start1 = 1'b0; ready1 = 1'b1;
    hold = 1'b0; done_due = 0; nrec = 0; ndone = 0;
    cyc(); cyc();

    chk("reset_flags", 128'({busy, done, rec_valid}), 128'(0));
    chk("reset_alu", 128'({alu_a, alu_b, alu_op}), 128'(0));
    chk("reset_rec", 128'({rec_a, rec_b, rec_op, rec_y, rec_idx}), 128'(0));
    rst = 1'b0;
    cyc();
    chk("idle_no_start", 128'(busy), 128'(0));

    // Run A: table-driven timing and contents of the first four records.
    nrec = 0; rec_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("drive_busy_valid", 128'({busy, rec_valid}), 128'(2'b10));
    chk("drive_alu_vec0", 128'({alu_a, alu_b, alu_op}), 128'({tbl[0].a, tbl[0].b, 3'd0}));
    for (k = 0; k < 4; k++) begin
      if (k > 0) begin
        cyc();
        chk("tbl_gap_valid", 128'(rec_valid), 128'(0));
      end
      cyc();
      chk("tbl_valid", 128'(rec_valid), 128'(1));
      chk("tbl_record", 128'({rec_idx, rec_op, rec_a, rec_b, rec_y}),
          128'({tbl[k].idx, 3'(k), tbl[k].a, tbl[k].b,
                alu_fn(tbl[k].a, tbl[k].b, 3'(k))}));
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_over_ready", 128'({busy, rec_valid, rec_idx, alu_a}), 128'(0));

    // Run B: backpressure on record 1, then reset during record 2.
    nrec = 0; rec_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rec_ready = 1'b0;
    cyc();
    chk("bp_rec1", 128'({rec_valid, rec_idx}), 128'({1'b1, 16'd1}));
    bp_a = alu_a;
    repeat (4) begin
      start = 1'b1;
      cyc();
    end
    start = 1'b0;
    chk("bp_still_rec1", 128'({rec_valid, rec_idx, alu_a}), 128'({1'b1, 16'd1, bp_a}));
    rec_ready = 1'b1;
    cyc();
    chk("bp_gap", 128'(rec_valid), 128'(0));
    rec_ready = 1'b0;
    cyc();
    chk("bp_rec2", 128'({rec_valid, rec_idx}), 128'({1'b1, 16'd2}));
    rst = 1'b1; start = 1'b1;
    cyc();
    chk("mid_emit_rst_flags", 128'({busy, done, rec_valid}), 128'(0));
    chk("mid_emit_rst_data", 128'({alu_a, alu_b, alu_op, rec_a, rec_b, rec_op, rec_y, rec_idx}),
        128'(0));
    rst = 1'b0; start = 1'b0;
    cyc();
    chk("start_with_rst_ignored", 128'(busy), 128'(0));

    // Run C: full run, random backpressure and stray start pulses.
    nrec = 0; ndone = 0; start = 1'b1;
    cyc();
    start = 1'b0;
    budget = 0;
    while (!(ndone >= 1 && !busy) && budget < 4000) begin
      rec_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      cyc();
      budget++;
    end
    start = 1'b0;
    chk("run_finished_in_budget", 128'(budget < 4000), 128'(1));
    chk("run_record_count", 128'(nrec), 128'(NV));
    chk("run_done_pulses", 128'(ndone), 128'(1));
    repeat (10) cyc();
    chk("no_extra_run", 128'({busy, 32'(nrec), 32'(ndone)}), 128'({1'b0, 32'(NV), 32'd1}));

    // Single-vector instance: one record, then done.
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("one_drive", 128'({busy1, valid1}), 128'(2'b10));
    cyc();
    chk("one_record", 128'({valid1, ridx1, rop1, ra1, rb1, ry1}),
        128'({1'b1, 16'd0, 3'd0, tbl[0].a, tbl[0].b, alu_fn(tbl[0].a, tbl[0].b, 3'd0)}));
    cyc();
    chk("one_done", 128'({done1, busy1, valid1}), 128'(3'b110));
    cyc();
    chk("one_idle", 128'({done1, busy1, valid1}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
